// File: rtl/fetch_queue.sv
// Instruction-fetch stage: pipelined memory requests feeding a DEPTH-entry in-order
// queue of {pc, ir} pairs for decode, with branch flush and stale-response dropping.
module fetch_queue #(
    parameter int unsigned IW       = 32,
    parameter int unsigned PC_W     = 30,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_INC   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [PC_W-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [IW-1:0]   rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [IW-1:0]   out_ir,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_addr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = AW + 2;

    // Three pointers with a wrap bit carve the ring into FILLED [rd,fill) and PENDING [fill,wr).
    logic [PC_W-1:0] fetch_pc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   drop_cnt;
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [IW-1:0]   ir_mem [DEPTH];

    logic [PW-1:0] alloc_cnt;
    logic [PW-1:0] pend_cnt;
    logic [PW-1:0] fill_cnt;
    logic [CW-1:0] busy_cnt;
    logic [PW-1:0] drop_on_br;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] rd_idx;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          pop_fire;

    assign alloc_cnt = wr_ptr - rd_ptr;
    assign pend_cnt  = wr_ptr - fill_ptr;
    assign fill_cnt  = fill_ptr - rd_ptr;
    assign busy_cnt  = CW'(alloc_cnt) + CW'(drop_cnt);
    assign wr_idx    = wr_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];

    // Outstanding memory responses are gated so entries plus in-flight drops never exceed DEPTH.
    assign req_valid = rst_n && !br_valid && (busy_cnt < CW'(DEPTH));
    assign req_addr  = fetch_pc;
    assign req_fire  = req_valid && req_ready;

    assign rsp_drop  = rsp_valid && !br_valid && (drop_cnt != '0);
    assign rsp_take  = rsp_valid && !br_valid && (drop_cnt == '0) && (pend_cnt != '0);

    assign out_valid = (fill_cnt != '0);
    assign out_pc    = out_valid ? pc_mem[rd_idx] : '0;
    assign out_ir    = out_valid ? ir_mem[rd_idx] : '0;
    assign pop_fire  = out_valid && out_ready && !br_valid;

    // Every request still in flight at a redirect becomes a response to throw away.
    assign drop_on_br = PW'(CW'(drop_cnt) + CW'(pend_cnt) - CW'(rsp_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= PC_W'(RESET_PC);
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else if (br_valid) begin
            fetch_pc <= br_addr;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            drop_cnt <= drop_on_br;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_W'(PC_INC);
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (rsp_take) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Payload storage needs no reset: reads are masked by out_valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_mem[wr_idx] <= fetch_pc;
        end
        if (rsp_take) begin
            ir_mem[fill_idx] <= rsp_data;
        end
    end

    property p_rsp_expected;
        @(posedge clk) disable iff (!rst_n)
            rsp_valid |-> ((drop_cnt != '0) || (pend_cnt != '0));
    endproperty
    a_rsp_expected: assert property (p_rsp_expected);

    property p_busy_bound;
        @(posedge clk) disable iff (!rst_n)
            busy_cnt <= CW'(DEPTH);
    endproperty
    a_busy_bound: assert property (p_busy_bound);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus an in-order
// fixed-latency memory model, directed scenarios and randomized traffic.
module tb_fetch_queue;

    localparam int unsigned IW     = 32;
    localparam int unsigned PC_W   = 30;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_INC = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [PC_W-1:0] req_addr;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [IW-1:0]   out_ir;
    logic            br_valid;
    logic [PC_W-1:0] br_addr;

    fetch_queue #(
        .IW(IW), .PC_W(PC_W), .DEPTH(DEPTH), .PC_INC(PC_INC), .RESET_PC(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
        .br_valid(br_valid), .br_addr(br_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            req_valid;
        logic [PC_W-1:0] req_addr;
        logic            out_valid;
        logic [PC_W-1:0] out_pc;
        logic [IW-1:0]   out_ir;
    } port_t;

    typedef struct {
        logic [PC_W-1:0] pc;
        bit              filled;
        logic [IW-1:0]   ir;
    } ent_t;

    typedef struct {
        logic [IW-1:0] data;
        int            due;
    } mrsp_t;

    ent_t            m_q[$];
    mrsp_t           mem_q[$];
    logic [PC_W-1:0] m_fpc;
    int              m_drop;
    int              cyc;
    int              cyc_s;
    int              mem_lat;
    port_t           exp_p;
    port_t           obs_p;
    int              n_cmp;
    int              n_err;

    function automatic logic [IW-1:0] mem_word(input logic [PC_W-1:0] a);
        return IW'(a) ^ 32'hA5A5_0000;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        mem_q.delete();
        m_fpc  = '0;
        m_drop = 0;
    endfunction

    function automatic port_t model_expect();
        port_t e;
        e.req_valid = rst_n && !br_valid && ((m_q.size() + m_drop) < int'(DEPTH));
        e.req_addr  = m_fpc;
        e.out_valid = (m_q.size() > 0) && m_q[0].filled;
        e.out_pc    = e.out_valid ? m_q[0].pc : '0;
        e.out_ir    = e.out_valid ? m_q[0].ir : '0;
        return e;
    endfunction

    function automatic void model_update();
        int              pend;
        int              idx;
        bit              acc;
        logic [PC_W-1:0] a;
        acc = exp_p.req_valid && req_ready;
        a   = exp_p.req_addr;
        if (br_valid) begin
            pend = 0;
            foreach (m_q[i]) if (!m_q[i].filled) pend++;
            m_drop = m_drop + pend - (rsp_valid ? 1 : 0);
            m_q.delete();
            m_fpc = br_addr;
        end else begin
            if (rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    idx = -1;
                    foreach (m_q[i]) if (idx < 0 && !m_q[i].filled) idx = i;
                    if (idx >= 0) begin
                        m_q[idx].filled = 1'b1;
                        m_q[idx].ir     = rsp_data;
                    end
                end
            end
            if (exp_p.out_valid && out_ready) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back('{pc: a, filled: 1'b0, ir: '0});
                m_fpc = m_fpc + PC_W'(PC_INC);
            end
        end
        if (rsp_valid) void'(mem_q.pop_front());
        if (acc) mem_q.push_back('{data: mem_word(a), due: cyc + mem_lat});
    endfunction

    // One clock: present memory response, sample at negedge, advance model at posedge.
    task automatic step();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_q[0].data;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        @(negedge clk);
        exp_p = model_expect();
        obs_p = {req_valid, req_addr, out_valid, out_pc, out_ir};
        @(posedge clk);
        model_update();
        cyc_s = cyc;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_ready = 1'b0;
        out_ready = 1'b0;
        br_valid  = 1'b0;
        br_addr   = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        br_valid = 1'b0;
        #1;
        obs_p = {req_valid, req_addr, out_valid, out_pc, out_ir};
        n_cmp++;
        if (obs_p !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=0", obs_p);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        mem_lat = 1;
        req_ready = 1'b1;
        step();
        n_cmp++;
        if (obs_p !== exp_p) begin
            n_err++;
            $display("FAIL reset_first_req cyc=%0d got=%h want=%h", cyc_s, obs_p, exp_p);
        end
    endtask

    task automatic test_stream();
        int              first_v;
        int              n_out;
        logic [PC_W-1:0] nxt;
        do_reset();
        mem_lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        first_v = -1; n_out = 0; nxt = '0;
        for (int k = 0; k < 24; k++) begin
            step();
            n_cmp++;
            if (obs_p !== exp_p) begin
                n_err++;
                $display("FAIL stream_model cyc=%0d got=%h want=%h", cyc_s, obs_p, exp_p);
            end
            if (obs_p.out_valid) begin
                if (first_v < 0) first_v = cyc_s;
                n_cmp++;
                if (obs_p.out_pc !== nxt || obs_p.out_ir !== mem_word(nxt)) begin
                    n_err++;
                    $display("FAIL stream_order got pc=%h ir=%h want pc=%h ir=%h",
                             obs_p.out_pc, obs_p.out_ir, nxt, mem_word(nxt));
                end
                nxt = nxt + PC_W'(PC_INC);
                n_out++;
            end
        end
        n_cmp++;
        if (first_v != 2 || n_out != 22) begin
            n_err++;
            $display("FAIL stream_latency got first=%0d count=%0d want first=2 count=22", first_v, n_out);
        end
    endtask

    task automatic test_stall();
        int              acc;
        int              got;
        logic [PC_W-1:0] pcs[4];
        do_reset();
        mem_lat = 1; req_ready = 1'b1; out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if (obs_p !== exp_p) begin
                n_err++;
                $display("FAIL stall_model cyc=%0d got=%h want=%h", cyc_s, obs_p, exp_p);
            end
            if (obs_p.req_valid && req_ready) acc++;
        end
        n_cmp++;
        if (acc != 4 || obs_p.req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_full got reqs=%0d req_valid=%b want reqs=4 req_valid=0", acc, obs_p.req_valid);
        end
        out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            n_cmp++;
            if (obs_p !== exp_p) begin
                n_err++;
                $display("FAIL stall_release_model cyc=%0d got=%h want=%h", cyc_s, obs_p, exp_p);
            end
            if (obs_p.out_valid && got < 4) begin
                pcs[got] = obs_p.out_pc;
                got++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got || pcs[i] !== PC_W'(4 * i)) begin
                n_err++;
                $display("FAIL stall_drain idx=%0d got=%h want=%h (got %0d entries)", i, pcs[i], PC_W'(4 * i), got);
            end
        end
    endtask

    task automatic test_branch();
        int              got;
        logic [PC_W-1:0] want;
        do_reset();
        mem_lat = 3; req_ready = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        br_valid = 1'b1; br_addr = PC_W'(32'h100);
        step();
        n_cmp++;
        if (obs_p !== exp_p || obs_p.req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL branch_cycle got=%h want=%h", obs_p, exp_p);
        end
        br_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n_cmp++;
            if (obs_p !== exp_p) begin
                n_err++;
                $display("FAIL branch_model cyc=%0d got=%h want=%h", cyc_s, obs_p, exp_p);
            end
            if (obs_p.out_valid && got < 3) begin
                want = PC_W'(32'h100 + 4 * got);
                n_cmp++;
                if (obs_p.out_pc !== want || obs_p.out_ir !== mem_word(want)) begin
                    n_err++;
                    $display("FAIL branch_target got pc=%h ir=%h want pc=%h", obs_p.out_pc, obs_p.out_ir, want);
                end
                got++;
            end
        end
        n_cmp++;
        if (got != 3) begin
            n_err++;
            $display("FAIL branch_timeout got %0d outputs want 3", got);
        end
    endtask

    task automatic test_br_collision();
        int got;
        do_reset();
        mem_lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        repeat (5) step();
        br_valid = 1'b1; br_addr = PC_W'(32'h200);
        step();
        br_valid = 1'b0;
        step();
        n_cmp++;
        if (obs_p !== exp_p || obs_p.req_valid !== 1'b1 || obs_p.req_addr !== PC_W'(32'h200)
            || obs_p.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL collide_restart got=%h want req_addr=200 out_valid=0", obs_p);
        end
        got = 0;
        for (int k = 0; k < 8 && got == 0; k++) begin
            step();
            if (obs_p.out_valid) begin
                got = 1;
                n_cmp++;
                if (obs_p.out_pc !== PC_W'(32'h200) || obs_p.out_ir !== mem_word(PC_W'(32'h200))) begin
                    n_err++;
                    $display("FAIL collide_first got pc=%h ir=%h want pc=200", obs_p.out_pc, obs_p.out_ir);
                end
            end
        end
        n_cmp++;
        if (got == 0) begin
            n_err++;
            $display("FAIL collide_timeout got no output want pc=200");
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] top;
        int              got;
        logic [PC_W-1:0] seq[2];
        top = '1;
        top = top - PC_W'(3);
        do_reset();
        mem_lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        step();
        br_valid = 1'b1; br_addr = top;
        step();
        br_valid = 1'b0;
        step();
        n_cmp++;
        if (obs_p.req_addr !== top || obs_p.req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_top got addr=%h valid=%b want addr=%h", obs_p.req_addr, obs_p.req_valid, top);
        end
        step();
        n_cmp++;
        if (obs_p.req_addr !== '0) begin
            n_err++;
            $display("FAIL wrap_zero got addr=%h want 0", obs_p.req_addr);
        end
        got = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_p.out_valid && got < 2) begin
                seq[got] = obs_p.out_pc;
                got++;
            end
        end
        n_cmp++;
        if (got != 2 || seq[0] !== top || seq[1] !== '0) begin
            n_err++;
            $display("FAIL wrap_out got %0d outputs pcs=%h,%h want %h,0", got, seq[0], seq[1], top);
        end
    endtask

    task automatic test_reset_mid();
        int first_v;
        do_reset();
        mem_lat = 2; req_ready = 1'b1; out_ready = 1'b1;
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        obs_p = {req_valid, req_addr, out_valid, out_pc, out_ir};
        n_cmp++;
        if (obs_p !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%h want=0", obs_p);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        first_v = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++;
            if (obs_p !== exp_p) begin
                n_err++;
                $display("FAIL midreset_model cyc=%0d got=%h want=%h", cyc_s, obs_p, exp_p);
            end
            if (obs_p.out_valid && first_v < 0) begin
                first_v = cyc_s;
                n_cmp++;
                if (obs_p.out_pc !== '0) begin
                    n_err++;
                    $display("FAIL midreset_resume got pc=%h want 0", obs_p.out_pc);
                end
            end
        end
    endtask

    task automatic test_random();
        bit prev_br;
        for (int pass = 0; pass < 3; pass++) begin
            do_reset();
            mem_lat = $urandom_range(1, 4);
            prev_br = 1'b0;
            for (int k = 0; k < 400; k++) begin
                req_ready = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                br_valid  = ($urandom_range(0, 19) == 0) || (prev_br && ($urandom_range(0, 1) == 1));
                br_addr   = PC_W'($urandom) & ~PC_W'(3);
                if ($urandom_range(0, 3) == 0) br_addr = ~PC_W'(0) - PC_W'(4 * $urandom_range(0, 3) + 3);
                prev_br = br_valid;
                step();
                n_cmp++;
                if (obs_p !== exp_p) begin
                    n_err++;
                    $display("FAIL random_model lat=%0d cyc=%0d got=%h want=%h", mem_lat, cyc_s, obs_p, exp_p);
                end
            end
            br_valid = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        mem_lat = 1;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_br_collision();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
